mic_req_arbiter: RTL and testbench
==================================

Name: mic_req_arbiter

Overview:
- Shares one MIC request port between NPORTS requesters, e.g. several m_requester-class masters or CPU/DMA front-ends.
- Arbitrates round-robin at packet granularity and stamps each requester's SRC_ID into the header.
- Demultiplexes the returning response stream (RDATA/WRACK) back to the originating port by header SRC_ID.
- Sits between the requesters and a single interconnect/MIC port.

Parameters:
- NPORTS, 4, number of requester ports; legal values 2..4.
- SRC_ID_BASE, 8'h10, base source ID; port p is stamped SRC_ID_BASE|p; SRC_ID_BASE[1:0] must be 0.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (0 = in reset, sampled on posedge clk).
- S_TVALID  in  NPORTS  per-port request valid.
- S_TREADY  out  NPORTS  per-port request ready.
- S_TDATA  in  64*NPORTS  per-port request beat; port p occupies [64p+63:64p].
- S_TLAST  in  NPORTS  per-port last beat of packet.
- M_TVALID / M_TREADY / M_TDATA[63:0] / M_TLAST  out/in/out/out  merged request stream to interconnect.
- R_TVALID / R_TREADY / R_TDATA[63:0] / R_TLAST  in/out/in/in  response stream from interconnect.
- D_TVALID  out  NPORTS  per-port response valid.
- D_TREADY  in  NPORTS  per-port response ready.
- D_TDATA  out  64  response data, broadcast to all ports.
- D_TLAST  out  1  response last, broadcast.
- drop_pulse  out  1  one-cycle pulse when an unroutable response header is accepted.

Behaviour:
- Header fields: [63:59] byte enables, [55:48] src_id, [47:40] rd_len, [33:32] type (00 RD, 01 WR, 10 RDATA, 11 WRACK), [31:3] address.
- Request FSM states: ARB_IDLE, ARB_BUSY.
- ARB_IDLE:
  - M_TVALID=0, all S_TREADY=0.
  - If any S_TVALID, pick the winner round-robin starting at ptr, register grant g, set hdr=1, go to ARB_BUSY.
  - Arbitration costs exactly 1 cycle.
- ARB_BUSY (combinational passthrough of port g):
  - M_TVALID=S_TVALID[g], S_TREADY[g]=M_TREADY; other S_TREADY=0.
  - M_TDATA=S_TDATA[g], M_TLAST=S_TLAST[g].
  - While hdr=1, M_TDATA[55:48] is replaced with SRC_ID_BASE|g; all other bits pass unmodified.
  - On handshake: hdr<=0.
  - On handshake with TLAST: ptr<=g+1 (mod NPORTS), go to ARB_IDLE.
  - Grant is never revoked mid-packet, including across TVALID gaps.
  - TLAST on the header beat (reads, zero-length writes) is legal: the single-beat packet then completes.
- Round-robin: after granting p, priority order is p+1, p+2, … wrapping. Reset sets ptr=0.
- Response path states: RSP_HDR, RSP_BODY.
- RSP_HDR:
  - dest=R_TDATA[49:48].
  - routable = (R_TDATA[55:50]==SRC_ID_BASE[7:2]) && dest<NPORTS.
  - If routable: D_TVALID[dest]=R_TVALID, R_TREADY=D_TREADY[dest].
  - If not routable: R_TREADY=1, all D_TVALID=0, and on handshake drop_pulse=1.
  - On handshake without R_TLAST: latch dest and routable, go to RSP_BODY.
- RSP_BODY:
  - Uses the latched dest; if not routable, R_TREADY=1 and beats are discarded.
  - On handshake with R_TLAST, return to RSP_HDR.
- D_TDATA=R_TDATA, D_TLAST=R_TLAST at all times; only one D_TVALID bit is ever high.
- Request and response paths are independent and progress on the same cycle.
- Reset values:
  - Request FSM = ARB_IDLE, response FSM = RSP_HDR, ptr=0, hdr=1.
  - M_TVALID=0, S_TREADY=0, R_TREADY=0, D_TVALID=0, drop_pulse=0.
- Reset mid-packet abandons the packet. Downstream is reset together with this block, so no recovery is needed.
- No combinational path from M_TREADY to M_TVALID, nor from D_TREADY to D_TVALID.

Decomposition:
- Shared package mic_pkt_defs:
  - field positions (SRC_ID_HI/LO, TYPE_HI/LO, LEN_HI/LO, ADDR_HI/LO);
  - type codes PKT_RD=2'b00, PKT_WR=2'b01, PKT_RDATA=2'b10, PKT_WRACK=2'b11.
- One sub-module, rr_pick: combinational round-robin pick taking req[NPORTS-1:0] and ptr, returning a one-hot grant and its index.

Test Plan:
- Single read from port 2, header src_id=8'h00, M_TREADY=1 → M beat 1 cycle after S_TVALID; M_TDATA[55:48]=8'h12; M_TLAST=1; S_TREADY[2] high for exactly 1 cycle.
- Port 0 sends a 4-beat write while port 1 requests a read, M_TREADY toggling 1/0 → all 4 write beats are contiguous with no port-1 beat interleaved; the port-1 read appears after one ARB_IDLE cycle.
- All 4 ports hold TVALID with single-beat reads for 8 packets, starting from reset → grant order 0,1,2,3,0,1,2,3.
- Response RDATA header src_id=8'h13 plus 3 data beats, D_TREADY[3] stalling every other cycle → only D_TVALID[3] asserts; 4 beats are delivered in order; R_TREADY tracks D_TREADY[3].
- WRACK with src_id=8'h42 → R_TREADY=1, no D_TVALID, drop_pulse=1 for one cycle; a following valid WRACK for 8'h11 is delivered to port 1.
- reset driven low during beat 2 of a 5-beat write → next cycle all outputs are at reset values; after release a new read from port 3 is granted normally.

Source files
------------

// File: rtl/mic_req_arbiter_pkg.sv
// MIC packet header field positions and type codes shared by the request
// arbiter, its round-robin picker and the bus interface.
package mic_pkt_defs;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned PORT_W    = 2;

  localparam int unsigned BE_HI     = 63;
  localparam int unsigned BE_LO     = 59;
  localparam int unsigned SRC_ID_HI = 55;
  localparam int unsigned SRC_ID_LO = 48;
  localparam int unsigned LEN_HI    = 47;
  localparam int unsigned LEN_LO    = 40;
  localparam int unsigned TYPE_HI   = 33;
  localparam int unsigned TYPE_LO   = 32;
  localparam int unsigned ADDR_HI   = 31;
  localparam int unsigned ADDR_LO   = 3;

  typedef enum logic [1:0] {
    PKT_RD    = 2'b00,
    PKT_WR    = 2'b01,
    PKT_RDATA = 2'b10,
    PKT_WRACK = 2'b11
  } pkt_type_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  typedef enum logic {
    RSP_HDR,
    RSP_BODY
  } rsp_state_e;

  typedef logic [PORT_W-1:0] port_idx_t;

  function automatic logic [7:0] stamp_id(input logic [7:0] base, input port_idx_t p);
    return base | {{(8-PORT_W){1'b0}}, p};
  endfunction

endpackage

// File: rtl/mic_req_arbiter_if.sv
// Bundles the per-port request streams, the merged MIC request stream and the
// response/demux streams that surround mic_req_arbiter.
interface mic_req_arbiter_if #(
  parameter int unsigned NPORTS = 4
);

  logic [NPORTS-1:0]                      S_TVALID;
  logic [NPORTS-1:0]                      S_TREADY;
  logic [mic_pkt_defs::DATA_W*NPORTS-1:0] S_TDATA;
  logic [NPORTS-1:0]                      S_TLAST;

  logic                                   M_TVALID;
  logic                                   M_TREADY;
  logic [mic_pkt_defs::DATA_W-1:0]        M_TDATA;
  logic                                   M_TLAST;

  logic                                   R_TVALID;
  logic                                   R_TREADY;
  logic [mic_pkt_defs::DATA_W-1:0]        R_TDATA;
  logic                                   R_TLAST;

  logic [NPORTS-1:0]                      D_TVALID;
  logic [NPORTS-1:0]                      D_TREADY;
  logic [mic_pkt_defs::DATA_W-1:0]        D_TDATA;
  logic                                   D_TLAST;

  // Arbiter side.
  modport slave (
    input  S_TVALID, S_TDATA, S_TLAST, M_TREADY,
    input  R_TVALID, R_TDATA, R_TLAST, D_TREADY,
    output S_TREADY, M_TVALID, M_TDATA, M_TLAST,
    output R_TREADY, D_TVALID, D_TDATA, D_TLAST
  );

  // Requester / interconnect side.
  modport master (
    output S_TVALID, S_TDATA, S_TLAST, M_TREADY,
    output R_TVALID, R_TDATA, R_TLAST, D_TREADY,
    input  S_TREADY, M_TVALID, M_TDATA, M_TLAST,
    input  R_TREADY, D_TVALID, D_TDATA, D_TLAST
  );

endinterface

// File: rtl/mic_req_arbiter_rr_pick.sv
// Combinational round-robin pick: first requesting port at or after ptr,
// wrapping, returned both one-hot and as an index.
module rr_pick
  import mic_pkt_defs::*;
#(
  parameter int unsigned NPORTS = 4
) (
  input  logic [NPORTS-1:0] req,
  input  port_idx_t         ptr,
  output logic [NPORTS-1:0] grant,
  output port_idx_t         idx,
  output logic              found
);

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < NPORTS; off++) begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
        if (!found && req[p] && (p == (32'(ptr) + off) % NPORTS)) begin
          grant[p] = 1'b1;
          idx      = port_idx_t'(p);
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mic_req_arbiter.sv
// Packet-granular round-robin merge of NPORTS requesters onto one MIC port,
// with SRC_ID stamping and demux of the response stream by header SRC_ID.
module mic_req_arbiter
  import mic_pkt_defs::*;
#(
  parameter int unsigned NPORTS      = 4,
  parameter logic [7:0]  SRC_ID_BASE = 8'h10
) (
  input  logic                clk,
  input  logic                reset,
  mic_req_arbiter_if.slave    bus,
  output logic                drop_pulse
);

  arb_state_e        arb_q, arb_d;
  port_idx_t         g_q, g_d;
  logic [NPORTS-1:0] goh_q, goh_d;
  port_idx_t         ptr_q, ptr_d;
  logic              hdr_q, hdr_d;

  logic [NPORTS-1:0] pick_grant;
  port_idx_t         pick_idx;
  logic              pick_found;

  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;

  logic              m_tvalid;
  logic [DATA_W-1:0] m_tdata;
  logic [NPORTS-1:0] s_tready;

  rr_pick #(.NPORTS(NPORTS)) u_pick (
    .req   (bus.S_TVALID),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      if (g_q == port_idx_t'(p)) begin
        sel_valid = bus.S_TVALID[p];
        sel_last  = bus.S_TLAST[p];
        sel_data  = bus.S_TDATA[p*DATA_W +: DATA_W];
      end
    end
  end

  // Grant is held until the TLAST handshake, so TVALID gaps never reopen arbitration.
  always_comb begin
    arb_d    = arb_q;
    g_d      = g_q;
    goh_d    = goh_q;
    ptr_d    = ptr_q;
    hdr_d    = hdr_q;
    m_tvalid = 1'b0;
    s_tready = '0;
    m_tdata  = sel_data;
    if (hdr_q) begin
      m_tdata[SRC_ID_HI:SRC_ID_LO] = stamp_id(SRC_ID_BASE, g_q);
    end
    case (arb_q)
      ARB_IDLE: begin
        if (pick_found) begin
          g_d   = pick_idx;
          goh_d = pick_grant;
          hdr_d = 1'b1;
          arb_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        m_tvalid = sel_valid;
        s_tready = goh_q & {NPORTS{bus.M_TREADY}};
        if (sel_valid && bus.M_TREADY) begin
          hdr_d = 1'b0;
          if (sel_last) begin
            ptr_d = (32'(g_q) == NPORTS - 1) ? '0 : g_q + port_idx_t'(1);
            arb_d = ARB_IDLE;
          end
        end
      end
      default: arb_d = ARB_IDLE;
    endcase
    if (!reset) begin
      m_tvalid = 1'b0;
      s_tready = '0;
    end
  end

  assign bus.M_TVALID = m_tvalid;
  assign bus.M_TDATA  = m_tdata;
  assign bus.M_TLAST  = sel_last;
  assign bus.S_TREADY = s_tready;

  rsp_state_e        rsp_q, rsp_d;
  port_idx_t         dest_q, dest_d;
  logic              rt_q, rt_d;

  port_idx_t         hdr_dest;
  logic              hdr_rt;
  port_idx_t         cur_dest;
  logic              cur_rt;
  logic [NPORTS-1:0] d_tvalid;
  logic              r_tready;
  logic              r_hs;
  logic              drop;

  assign hdr_dest = bus.R_TDATA[SRC_ID_LO+PORT_W-1:SRC_ID_LO];
  assign hdr_rt   = (bus.R_TDATA[SRC_ID_HI:SRC_ID_LO+PORT_W] == SRC_ID_BASE[7:PORT_W]) &&
                    (32'(hdr_dest) < NPORTS);
  assign cur_dest = (rsp_q == RSP_HDR) ? hdr_dest : dest_q;
  assign cur_rt   = (rsp_q == RSP_HDR) ? hdr_rt   : rt_q;

  // Unroutable packets are sunk at full rate; only their header beat pulses drop.
  always_comb begin
    d_tvalid = '0;
    r_tready = 1'b1;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      if (cur_rt && (cur_dest == port_idx_t'(p))) begin
        d_tvalid[p] = bus.R_TVALID;
        r_tready    = bus.D_TREADY[p];
      end
    end
    if (!reset) begin
      d_tvalid = '0;
      r_tready = 1'b0;
    end
    r_hs = bus.R_TVALID && r_tready;
    drop = r_hs && (rsp_q == RSP_HDR) && !hdr_rt;
  end

  always_comb begin
    rsp_d  = rsp_q;
    dest_d = dest_q;
    rt_d   = rt_q;
    case (rsp_q)
      RSP_HDR: begin
        if (r_hs && !bus.R_TLAST) begin
          dest_d = hdr_dest;
          rt_d   = hdr_rt;
          rsp_d  = RSP_BODY;
        end
      end
      RSP_BODY: begin
        if (r_hs && bus.R_TLAST) begin
          rsp_d = RSP_HDR;
        end
      end
      default: rsp_d = RSP_HDR;
    endcase
  end

  assign bus.D_TVALID = d_tvalid;
  assign bus.R_TREADY = r_tready;
  assign bus.D_TDATA  = bus.R_TDATA;
  assign bus.D_TLAST  = bus.R_TLAST;
  assign drop_pulse   = drop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      arb_q  <= ARB_IDLE;
      g_q    <= '0;
      goh_q  <= '0;
      ptr_q  <= '0;
      hdr_q  <= 1'b1;
      rsp_q  <= RSP_HDR;
      dest_q <= '0;
      rt_q   <= 1'b0;
    end else begin
      arb_q  <= arb_d;
      g_q    <= g_d;
      goh_q  <= goh_d;
      ptr_q  <= ptr_d;
      hdr_q  <= hdr_d;
      rsp_q  <= rsp_d;
      dest_q <= dest_d;
      rt_q   <= rt_d;
    end
  end

endmodule

// File: tb/tb_mic_req_arbiter.sv
// Self-checking bench for mic_req_arbiter: directed scenarios plus randomized
// request/response traffic checked against a packet-level reference model.
module tb_mic_req_arbiter;
  import mic_pkt_defs::*;

  localparam int unsigned NP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        drop_pulse;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  mic_req_arbiter_if #(.NPORTS(NP)) bus ();

  mic_req_arbiter #(.NPORTS(NP), .SRC_ID_BASE(8'h10)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .drop_pulse (drop_pulse)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_in();
    bus.S_TVALID = '0;
    bus.S_TDATA  = '0;
    bus.S_TLAST  = '0;
    bus.M_TREADY = 1'b0;
    bus.R_TVALID = 1'b0;
    bus.R_TDATA  = '0;
    bus.R_TLAST  = 1'b0;
    bus.D_TREADY = '0;
  endtask

  function automatic logic [63:0] mkhdr(input logic [7:0] src, input logic [1:0] ty);
    logic [63:0] h;
    h = {$urandom, $urandom};
    h[55:48] = src;
    h[33:32] = ty;
    return h;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_tvalid"}, 64'(bus.M_TVALID), 0);
    chk({tag, "_s_tready"}, 64'(bus.S_TREADY), 0);
    chk({tag, "_r_tready"}, 64'(bus.R_TREADY), 0);
    chk({tag, "_d_tvalid"}, 64'(bus.D_TVALID), 0);
    chk({tag, "_drop"},     64'(drop_pulse),   0);
  endtask

  initial begin
    logic [63:0] h, e;
    logic [63:0] rb[4];
    logic [63:0] pq[NP][$];
    bit          pl[NP][$];
    int          npk[NP], rem[NP], ip[NP], pos[NP];
    logic [63:0] ed[$];
    bit          el[$];
    int          ep[$];
    logic [63:0] rq[$];
    bit          rlst[$], rhd[$];
    int          rdst[$];
    int          got, b, ptr, left, len, p, src_p;
    bit          tog, hdrbeat, routable, exprdy;
    logic [3:0]  expv;

    // Reset: outputs quiet even with an unroutable response and all requests pending.
    reset = 1'b0;
    idle_in();
    nxt();
    bus.S_TVALID = '1;
    bus.M_TREADY = 1'b1;
    bus.R_TVALID = 1'b1;
    bus.R_TDATA  = mkhdr(8'h42, PKT_WRACK);
    bus.R_TLAST  = 1'b1;
    smp();
    chk_reset_outputs("rst");
    nxt();
    idle_in();
    reset = 1'b1;
    nxt();

    // Single read from port 2: one arbitration cycle, stamped src_id 8'h12.
    h = mkhdr(8'h00, PKT_RD);
    bus.S_TVALID = 4'b0100;
    bus.S_TDATA[2*64 +: 64] = h;
    bus.S_TLAST  = 4'b0100;
    bus.M_TREADY = 1'b1;
    smp();
    chk("rd_arb_gap", 64'(bus.M_TVALID), 0);
    nxt();
    smp();
    e = h;
    e[55:48] = 8'h12;
    chk("rd_m_tvalid", 64'(bus.M_TVALID), 1);
    chk("rd_m_tdata",  bus.M_TDATA, e);
    chk("rd_m_tlast",  64'(bus.M_TLAST), 1);
    chk("rd_s_tready", 64'(bus.S_TREADY), 64'h4);
    nxt();
    idle_in();
    smp();
    chk("rd_s_tready_once", 64'(bus.S_TREADY), 0);
    nxt();

    // All ports hold single-beat reads from reset: grants 0,1,2,3,0,1,2,3.
    reset = 1'b0;
    nxt();
    reset = 1'b1;
    for (int i = 0; i < NP; i++) bus.S_TDATA[i*64 +: 64] = mkhdr(8'h00, PKT_RD);
    bus.S_TVALID = '1;
    bus.S_TLAST  = '1;
    bus.M_TREADY = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      smp();
      if (bus.M_TVALID) begin
        chk("rr_src_id",  64'(bus.M_TDATA[55:48]), 64'(8'h10 | (got % 4)));
        chk("rr_s_tready", 64'(bus.S_TREADY), 64'(1 << (got % 4)));
        got++;
      end
      nxt();
    end
    chk("rr_count", 64'(got), 8);
    idle_in();
    nxt();

    // RDATA for src 8'h13 with 3 data beats, port 3 stalling every other cycle.
    rb[0] = mkhdr(8'h13, PKT_RDATA);
    for (int i = 1; i < 4; i++) rb[i] = {$urandom, $urandom};
    b = 0;
    for (int c = 0; c < 30 && b < 4; c++) begin
      tog = (c % 2 == 1);
      bus.D_TREADY = {tog, 3'b111};
      bus.R_TVALID = 1'b1;
      bus.R_TDATA  = rb[b];
      bus.R_TLAST  = (b == 3);
      smp();
      chk("rsp_d_tvalid", 64'(bus.D_TVALID), 64'h8);
      chk("rsp_r_tready", 64'(bus.R_TREADY), 64'(tog));
      chk("rsp_d_tdata",  bus.D_TDATA, rb[b]);
      chk("rsp_d_tlast",  64'(bus.D_TLAST), 64'(b == 3));
      if (tog) b++;
      nxt();
    end
    chk("rsp_beats", 64'(b), 4);

    // Unroutable WRACK is dropped, then a WRACK for 8'h11 goes to port 1.
    bus.D_TREADY = '0;
    bus.R_TVALID = 1'b1;
    bus.R_TDATA  = mkhdr(8'h42, PKT_WRACK);
    bus.R_TLAST  = 1'b1;
    smp();
    chk("drop_pulse",    64'(drop_pulse), 1);
    chk("drop_r_tready", 64'(bus.R_TREADY), 1);
    chk("drop_d_tvalid", 64'(bus.D_TVALID), 0);
    nxt();
    bus.R_TDATA  = mkhdr(8'h11, PKT_WRACK);
    bus.D_TREADY = 4'b0010;
    smp();
    chk("wrack_drop",     64'(drop_pulse), 0);
    chk("wrack_d_tvalid", 64'(bus.D_TVALID), 64'h2);
    chk("wrack_r_tready", 64'(bus.R_TREADY), 1);
    nxt();
    idle_in();
    nxt();

    // Reset during beat 2 of a 5-beat write, then a fresh read from port 3.
    bus.S_TVALID = 4'b0001;
    bus.S_TDATA[63:0] = mkhdr(8'h00, PKT_WR);
    bus.M_TREADY = 1'b1;
    smp();
    nxt();
    smp();
    chk("mid_beat1", 64'(bus.M_TVALID), 1);
    nxt();
    bus.S_TDATA[63:0] = {$urandom, $urandom};
    bus.R_TVALID = 1'b1;
    bus.R_TDATA  = mkhdr(8'h42, PKT_WRACK);
    reset = 1'b0;
    nxt();
    smp();
    chk_reset_outputs("mid_rst");
    nxt();
    reset = 1'b1;
    idle_in();
    h = mkhdr(8'h00, PKT_RD);
    bus.S_TVALID = 4'b1000;
    bus.S_TDATA[3*64 +: 64] = h;
    bus.S_TLAST  = 4'b1000;
    bus.M_TREADY = 1'b1;
    smp();
    chk("post_rst_gap", 64'(bus.M_TVALID), 0);
    nxt();
    smp();
    chk("post_rst_src",   64'(bus.M_TDATA[55:48]), 64'h13);
    chk("post_rst_ready", 64'(bus.S_TREADY), 64'h8);
    nxt();
    idle_in();
    reset = 1'b0;
    nxt();
    reset = 1'b1;

    // Randomized requests: model orders whole packets round-robin over ports with work left.
    for (int i = 0; i < NP; i++) begin
      npk[i] = $urandom_range(0, 3);
      for (int k = 0; k < npk[i]; k++) begin
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) begin
          pq[i].push_back(j == 0 ? mkhdr(8'($urandom), 2'($urandom_range(0, 1)))
                                 : {$urandom, $urandom});
          pl[i].push_back(j == len - 1);
        end
      end
      rem[i] = npk[i];
      ip[i]  = 0;
      pos[i] = 0;
    end
    ptr  = 0;
    left = npk[0] + npk[1] + npk[2] + npk[3];
    while (left > 0) begin
      p = -1;
      for (int off = 0; off < NP; off++)
        if (p < 0 && rem[(ptr + off) % NP] > 0) p = (ptr + off) % NP;
      for (int j = 0; ; j++) begin
        e = pq[p][ip[p]];
        if (j == 0) e[55:48] = 8'h10 | 8'(p);
        ed.push_back(e);
        el.push_back(pl[p][ip[p]]);
        ep.push_back(p);
        ip[p]++;
        if (pl[p][ip[p] - 1]) break;
      end
      rem[p]--;
      left--;
      ptr = (p + 1) % NP;
    end
    for (int c = 0; c < 3000 && ed.size() > 0; c++) begin
      for (int i = 0; i < NP; i++) begin
        if (pos[i] < pq[i].size()) begin
          hdrbeat = (pos[i] == 0) ? 1'b1 : pl[i][pos[i] - 1];
          bus.S_TVALID[i] = hdrbeat || ($urandom_range(0, 3) != 0);
          bus.S_TDATA[i*64 +: 64] = pq[i][pos[i]];
          bus.S_TLAST[i] = pl[i][pos[i]];
        end else begin
          bus.S_TVALID[i] = 1'b0;
          bus.S_TLAST[i]  = 1'b0;
        end
      end
      bus.M_TREADY = ($urandom_range(0, 9) < 7);
      smp();
      if (bus.M_TVALID && bus.M_TREADY) begin
        chk("req_rand_data", bus.M_TDATA, ed[0]);
        chk("req_rand_last", 64'(bus.M_TLAST), 64'(el[0]));
        chk("req_rand_port", 64'(bus.S_TVALID & bus.S_TREADY), 64'(1 << ep[0]));
        void'(ed.pop_front());
        void'(el.pop_front());
        void'(ep.pop_front());
      end
      for (int i = 0; i < NP; i++)
        if (bus.S_TVALID[i] && bus.S_TREADY[i]) pos[i]++;
      nxt();
    end
    chk("req_drain", 64'(ed.size()), 0);
    idle_in();
    nxt();

    // Randomized responses: each beat is routed by its packet's header src_id.
    for (int k = 0; k < 14; k++) begin
      len      = $urandom_range(1, 4);
      routable = ($urandom_range(0, 3) != 0);
      src_p    = $urandom_range(0, 3);
      for (int j = 0; j < len; j++) begin
        rq.push_back(j == 0 ? mkhdr((routable ? 8'h10 : 8'h40) | 8'(src_p),
                                    2'($urandom_range(2, 3)))
                            : {$urandom, $urandom});
        rlst.push_back(j == len - 1);
        rhd.push_back(j == 0);
        rdst.push_back(routable ? src_p : -1);
      end
    end
    for (int c = 0; c < 3000 && rq.size() > 0; c++) begin
      bus.R_TVALID = ($urandom_range(0, 4) != 0);
      bus.R_TDATA  = rq[0];
      bus.R_TLAST  = rlst[0];
      bus.D_TREADY = 4'($urandom);
      smp();
      if (bus.R_TVALID) begin
        expv   = (rdst[0] >= 0) ? 4'(1 << rdst[0]) : 4'b0000;
        exprdy = (rdst[0] >= 0) ? bus.D_TREADY[rdst[0]] : 1'b1;
        chk("rsp_rand_d_tvalid", 64'(bus.D_TVALID), 64'(expv));
        chk("rsp_rand_r_tready", 64'(bus.R_TREADY), 64'(exprdy));
        chk("rsp_rand_drop",     64'(drop_pulse), 64'(rdst[0] < 0 && rhd[0]));
        chk("rsp_rand_d_tdata",  bus.D_TDATA, rq[0]);
        if (exprdy) begin
          void'(rq.pop_front());
          void'(rlst.pop_front());
          void'(rhd.pop_front());
          void'(rdst.pop_front());
        end
      end else begin
        chk("rsp_rand_idle_d_tvalid", 64'(bus.D_TVALID), 0);
        chk("rsp_rand_idle_drop",     64'(drop_pulse), 0);
      end
      nxt();
    end
    chk("rsp_drain", 64'(rq.size()), 0);
    idle_in();
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
